// File: rtl/serial_compare_ctrl.sv
// Serial magnitude comparator: walks 2-bit slices MSB-first, one per clock.
// Optional macro SIGNED_CMP_EN selects two's-complement compare.
module serial_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [WIDTH-1:0]            a_in,
    input  logic [WIDTH-1:0]            b_in,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic                        a_gt_b,
    output logic                        a_eq_b,
    output logic                        a_lt_b,
    output logic [$clog2(WIDTH/2):0]    steps
);

    localparam int S  = WIDTH / 2;
    localparam int IW = (S > 1) ? $clog2(S) : 1;
    localparam int SW = $clog2(S) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [SW-1:0]     steps_q, steps_d;
    logic              gt_q, gt_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;

    logic [IW:0]       bit_pos;
    logic [1:0]        sa, sb;
    logic              top_slice;

    assign bit_pos   = {idx_q, 1'b0};
    assign top_slice = (idx_q == IW'(S - 1));

    always_comb begin
        sa = a_q[bit_pos +: 2];
        sb = b_q[bit_pos +: 2];
`ifdef SIGNED_CMP_EN
        // Flipping both sign bits maps two's complement order onto unsigned order.
        if (top_slice) begin
            sa[1] = ~sa[1];
            sb[1] = ~sb[1];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            steps_q <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            steps_q <= steps_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        steps_d = steps_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    idx_d   = IW'(S - 1);
                    steps_d = '0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                steps_d = steps_q + SW'(1);
                if (sa > sb) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (sa < sb) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (result_ready) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    steps_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Results are exposed only in DONE so partial counts never leak out.
    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign a_gt_b       = result_valid & gt_q;
    assign a_eq_b       = result_valid & eq_q;
    assign a_lt_b       = result_valid & lt_q;
    assign steps        = result_valid ? steps_q : '0;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl (WIDTH=8).
module tb_serial_compare_ctrl;

    localparam int W = 8;
    localparam int S = W / 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in, b_in;
    logic         result_valid;
    logic         result_ready;
    logic         a_gt_b, a_eq_b, a_lt_b;
    logic [2:0]   steps;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   st;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .a_gt_b       (a_gt_b),
        .a_eq_b       (a_eq_b),
        .a_lt_b       (a_lt_b),
        .steps        (steps)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.st = S;
        for (int i = S - 1; i >= 0; i--) begin
            if (a[2*i +: 2] != b[2*i +: 2]) begin
                e.st = S - i;
                break;
            end
        end
`ifdef SIGNED_CMP_EN
        e.gt = $signed(a) > $signed(b);
        e.lt = $signed(a) < $signed(b);
`else
        e.gt = a > b;
        e.lt = a < b;
`endif
        e.eq = (a == b);
        return e;
    endfunction

    task automatic idle_check(input string tag);
        check({tag, "_rv"}, {31'd0, result_valid}, 32'd0);
        check({tag, "_sr"}, {31'd0, start_ready}, 32'd1);
        check({tag, "_flags"}, {29'd0, a_gt_b, a_eq_b, a_lt_b}, 32'd0);
        check({tag, "_steps"}, {29'd0, steps}, 32'd0);
    endtask

    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        exp_t e;
        int   n;
        check("req_ready", {31'd0, start_ready}, 32'd1);
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
        sbq.push_back(model(a, b));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a_in        = W'($urandom);
        b_in        = W'($urandom);
        check("busy_ready", {31'd0, start_ready}, 32'd0);
        n = 0;
        while (n <= S + 2) begin
            @(posedge clk);
            #1;
            n++;
            if (result_valid) break;
        end
        if (!result_valid) begin
            check("timeout", 32'd0, 32'd1);
            sbq.delete();
            return;
        end
        if (sbq.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sbq.pop_front();
        check("latency", 32'(n), 32'(e.st));
        check("flags", {29'd0, a_gt_b, a_eq_b, a_lt_b}, {29'd0, e.gt, e.eq, e.lt});
        check("steps", {29'd0, steps}, 32'(e.st));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check("hold_rv", {31'd0, result_valid}, 32'd1);
            check("hold_flags", {29'd0, a_gt_b, a_eq_b, a_lt_b},
                  {29'd0, e.gt, e.eq, e.lt});
            check("hold_steps", {29'd0, steps}, 32'(e.st));
            check("hold_sr", {31'd0, start_ready}, 32'd0);
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        idle_check("bubble");
    endtask

    initial begin
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        a_in         = '0;
        b_in         = '0;
        #2;
        idle_check("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_check("post_reset");

        do_cmp(8'hA5, 8'h35, 0);
        do_cmp(8'h3C, 8'h3C, 0);
        do_cmp(8'h12, 8'h13, 0);
        do_cmp(8'h40, 8'h00, 5);
        do_cmp(8'h80, 8'h01, 0);
        do_cmp(8'h00, 8'hFF, 1);
        do_cmp(8'hFF, 8'hFE, 0);

        // Abort mid-RUN: no result must appear
        start_valid = 1'b1;
        a_in        = 8'h03;
        b_in        = 8'h02;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        idle_check("abort");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < S + 1; k++) begin
            @(posedge clk);
            #1;
            check("abort_idle_rv", {31'd0, result_valid}, 32'd0);
        end
        do_cmp(8'h01, 8'h02, 0);

        // Ready during RUN must not complete anything early
        start_valid = 1'b1;
        a_in        = 8'h11;
        b_in        = 8'h10;
        @(posedge clk);
        #1;
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        check("run_rdy_rv", {31'd0, result_valid}, 32'd0);
        check("run_rdy_sr", {31'd0, start_ready}, 32'd0);
        result_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        for (int r = 0; r < 24; r++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (r % 3 == 0) ? ra ^ W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
            if (r % 5 == 0) rb = ra;
            do_cmp(ra, rb, r % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
